// File: rtl/meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : meter_pkg
//  Description : Shared constants and timebase helpers for the parking-meter
//                design (system clock rate, default blink rate, half-period
//                and counter-width calculations).
//  Revision    : 1.0 - initial release
// ============================================================================
package meter_pkg;

  // System clock frequency in Hz.
  localparam int c_CLK_HZ   = 100_000_000;

  // Default display blink frequency in Hz.
  localparam int c_BLINK_HZ = 2;

  // Number of clk cycles in one half period of an out_hz square wave.
  // Degenerate requests are clamped to 1 so that elaboration can reach the
  // legality checks in the consumer instead of failing on a zero width.
  function automatic int half_period(input int clk_hz, input int out_hz);
    int half;
    if (out_hz < 1) begin
      half = 1;
    end else begin
      half = clk_hz / (2 * out_hz);
    end
    if (half < 1) begin
      half = 1;
    end
    return half;
  endfunction

  // Counter width able to hold 0 .. half-1, never narrower than one bit.
  function automatic int cnt_width(input int half);
    int w;
    if (half > 1) begin
      w = $clog2(half);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage : meter_pkg
`default_nettype wire

// File: rtl/sq_div.sv
`default_nettype none
// ============================================================================
//  Module      : sq_div
//  Description : Square-wave divider. Counts HALF clk cycles, then wraps the
//                counter and toggles the output in the same registered
//                update, giving a 50 % duty wave of period 2*HALF cycles.
//                The output is taken straight from a flop, so it is
//                glitch-free.
//  Revision    : 1.0 - initial release
// ============================================================================
module sq_div
  import meter_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic rst,
  output logic out
);

  localparam int                 c_CNT_W = cnt_width(HALF);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(HALF - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_out;

  // Half-period counter and toggle flop; reset clears both immediately so a
  // release always starts a fresh, full low half period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (r_cnt == c_LAST) begin
      r_cnt <= '0;
      r_out <= ~r_out;
    end else begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

  assign out = r_out;

endmodule : sq_div
`default_nettype wire

// File: rtl/clocks_div.sv
`default_nettype none
// ============================================================================
//  Module      : clocks_div
//  Description : Derives a 1 Hz timebase and a BLINK_HZ display-blink wave
//                from the system clock. Both are registered 50 % duty square
//                waves. Because the 1 Hz half period is an exact multiple of
//                the blink half period and both counters restart together
//                from reset, every clk_1Hz toggle lands on the same clk edge
//                as a clk_blink toggle.
//  Revision    : 1.0 - initial release
// ============================================================================
module clocks_div
  import meter_pkg::*;
#(
  parameter int CLK_HZ   = c_CLK_HZ,
  parameter int BLINK_HZ = c_BLINK_HZ
) (
  input  logic clk,
  input  logic rst,
  output logic clk_1Hz,
  output logic clk_blink
);

  localparam int c_HALF_1HZ   = half_period(CLK_HZ, 1);
  localparam int c_HALF_BLINK = half_period(CLK_HZ, BLINK_HZ);

  // Reject parameter sets that cannot give exact, phase-coherent outputs.
  if (CLK_HZ < 2) begin : g_bad_clk_hz
    $error("clocks_div: CLK_HZ must be at least 2");
  end
  if (BLINK_HZ < 1) begin : g_bad_blink_hz
    $error("clocks_div: BLINK_HZ must be at least 1");
  end else if ((CLK_HZ % (2 * BLINK_HZ)) != 0) begin : g_bad_ratio
    $error("clocks_div: CLK_HZ must be divisible by 2*BLINK_HZ");
  end

  // 1 Hz countdown timebase.
  sq_div #(
    .HALF (c_HALF_1HZ)
  ) u_div_1hz (
    .clk (clk),
    .rst (rst),
    .out (clk_1Hz)
  );

  // Display blink wave.
  sq_div #(
    .HALF (c_HALF_BLINK)
  ) u_div_blink (
    .clk (clk),
    .rst (rst),
    .out (clk_blink)
  );

endmodule : clocks_div
`default_nettype wire

// File: tb/tb_clocks_div.sv
`timescale 1ns/10ps
`default_nettype none
// ============================================================================
//  Module      : tb_clocks_div
//  Description : Self-checking bench for clocks_div. Instance A uses
//                CLK_HZ=20/BLINK_HZ=2, instance B uses CLK_HZ=24/BLINK_HZ=3.
//                Expected outputs come from the rule "output = bit 0 of
//                (edges since release / half period)", 0 while in reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clocks_div;

  localparam int A_CLK_HZ = 20;
  localparam int A_BLINK  = 2;
  localparam int B_CLK_HZ = 24;
  localparam int B_BLINK  = 3;

  localparam int A_H1 = A_CLK_HZ / 2;             // 10
  localparam int A_HB = A_CLK_HZ / (2 * A_BLINK); // 5
  localparam int B_H1 = B_CLK_HZ / 2;             // 12
  localparam int B_HB = B_CLK_HZ / (2 * B_BLINK); // 4

  logic clk;
  logic rst;
  logic a_1hz, a_blink, b_1hz, b_blink;

  int checks   = 0;
  int failures = 0;
  int n        = 0;    // rising edges since reset release
  bit in_rst   = 1'b1;

  clocks_div #(.CLK_HZ(A_CLK_HZ), .BLINK_HZ(A_BLINK)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .clk_1Hz   (a_1hz),
    .clk_blink (a_blink)
  );

  clocks_div #(.CLK_HZ(B_CLK_HZ), .BLINK_HZ(B_BLINK)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .clk_1Hz   (b_1hz),
    .clk_blink (b_blink)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  typedef struct {
    int k;
    bit e_1hz;
    bit e_blink;
  } vec_t;

  vec_t vecs[12];

  function automatic bit model(input int half, input int edges, input bit rst_active);
    if (rst_active) return 1'b0;
    return ((edges / half) % 2) == 1;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b n=%0d t=%0t", name, act, exp, n, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_a_1hz"},   a_1hz,   model(A_H1, n, in_rst));
    chk({tag, "_a_blink"}, a_blink, model(A_HB, n, in_rst));
    chk({tag, "_b_1hz"},   b_1hz,   model(B_H1, n, in_rst));
    chk({tag, "_b_blink"}, b_blink, model(B_HB, n, in_rst));
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    if (!in_rst) n++;
    #0.5;
  endtask

  task automatic release_rst();
    rst    = 1'b1;
    in_rst = 1'b0;
    n      = 0;
  endtask

  // Replays the post-release sequence for instance A from hand-derived values.
  task automatic run_table(input string tag);
    for (int i = 0; i < 12; i++) begin
      while (n < vecs[i].k) step();
      chk($sformatf("%s_tbl%0d_1hz", tag, vecs[i].k),   a_1hz,   vecs[i].e_1hz);
      chk($sformatf("%s_tbl%0d_blink", tag, vecs[i].k), a_blink, vecs[i].e_blink);
    end
  endtask

  initial begin
    logic p1, pb, q1, qb;
    int   cnt;
    bit   seen;

    vecs[0]  = '{0,  1'b0, 1'b0};
    vecs[1]  = '{4,  1'b0, 1'b0};
    vecs[2]  = '{5,  1'b0, 1'b1};
    vecs[3]  = '{9,  1'b0, 1'b1};
    vecs[4]  = '{10, 1'b1, 1'b0};
    vecs[5]  = '{14, 1'b1, 1'b0};
    vecs[6]  = '{15, 1'b1, 1'b1};
    vecs[7]  = '{19, 1'b1, 1'b1};
    vecs[8]  = '{20, 1'b0, 1'b0};
    vecs[9]  = '{24, 1'b0, 1'b0};
    vecs[10] = '{25, 1'b0, 1'b1};
    vecs[11] = '{30, 1'b1, 1'b0};

    // Reset hold for 100 ns while clk runs.
    rst    = 1'b0;
    in_rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("rst_hold_a_1hz",   a_1hz,   1'b0);
      chk("rst_hold_a_blink", a_blink, 1'b0);
      chk("rst_hold_b_1hz",   b_1hz,   1'b0);
      chk("rst_hold_b_blink", b_blink, 1'b0);
    end

    // Release between edges and walk the first sequence.
    #0.5;
    release_rst();
    run_table("rel");

    // Steady state: model compare plus coherence of toggles.
    for (int i = 0; i < 200; i++) begin
      p1 = a_1hz; pb = a_blink; q1 = b_1hz; qb = b_blink;
      step();
      chk_model("steady");
      if (a_1hz !== p1) chk("coherent_a", a_blink ^ pb, 1'b1);
      if (b_1hz !== q1) chk("coherent_b", b_blink ^ qb, 1'b1);
    end

    // Mid-phase asynchronous reset, 3 edges after a clk_1Hz rise.
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      p1 = a_1hz;
      step();
      if (!p1 && a_1hz) seen = 1'b1;
    end
    chk("find_1hz_rise", seen, 1'b1);
    step(); step(); step();
    #0.2;
    rst    = 1'b0;
    in_rst = 1'b1;
    #0.2;
    chk("async_rst_a_1hz",   a_1hz,   1'b0);
    chk("async_rst_a_blink", a_blink, 1'b0);
    chk("async_rst_b_1hz",   b_1hz,   1'b0);
    chk("async_rst_b_blink", b_blink, 1'b0);
    #0.3;
    release_rst();
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      cnt++;
      if (a_1hz) seen = 1'b1;
    end
    chk("rise_after_rst_seen", seen, 1'b1);
    chk("rise_after_rst_at10", cnt == A_H1, 1'b1);

    // Short reset pulse (well under one clk period), then replay the table.
    repeat (7) step();
    #0.3;
    rst    = 1'b0;
    in_rst = 1'b1;
    #0.4;
    chk_model("short_pulse");
    release_rst();
    run_table("short");

    // Randomized run lengths and reset pulses against the reference model.
    for (int it = 0; it < 20; it++) begin
      int run_len;
      int hold;
      run_len = int'($urandom_range(60, 1));
      for (int i = 0; i < run_len; i++) begin
        step();
        chk_model("rand_run");
      end
      hold = int'($urandom_range(3, 0));
      #($urandom_range(9, 1) * 0.1);
      rst    = 1'b0;
      in_rst = 1'b1;
      #0.05;
      chk_model("rand_rst");
      for (int i = 0; i < hold; i++) begin
        step();
        chk_model("rand_hold");
      end
      release_rst();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_clocks_div
`default_nettype wire
